// File: rtl/nf_req_arb.sv
// nf_req_arb: two-master round-robin arbiter in front of the single
// core-side memory request port. It holds one buffered request per master,
// runs one downstream transaction at a time, and has a response watchdog.
module nf_req_arb #(
  parameter int unsigned timeout_c = 64,
  parameter int unsigned cnt_w     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0][31:0] addr_m,
  input  logic [1:0][31:0] wd_m,
  input  logic [1:0]       we_m,
  input  logic [1:0]       req_m,
  output logic [1:0][31:0] rd_m,
  output logic [1:0]       req_ack_m,
  output logic [1:0]       err_m,
  output logic [31:0]      addr_s,
  output logic [31:0]      wd_s,
  output logic             we_s,
  output logic             req_s,
  input  logic [31:0]      rd_s,
  input  logic             req_ack_s
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t           r_state, w_state;
  logic [1:0]       r_pend, w_pend;
  logic             r_last, w_last;
  logic             r_grant, w_grant;
  logic [cnt_w-1:0] r_wd, w_wd;
  logic [1:0][31:0] r_buf_addr, r_buf_wd;
  logic [1:0]       r_buf_we;
  logic [1:0][31:0] r_rd, w_rd;
  logic [1:0]       r_ack, w_ack, r_err, w_err;
  logic [31:0]      r_addr_s, w_addr_s, r_wd_s, w_wd_s;
  logic             r_we_s, w_we_s, r_req_s, w_req_s;
  logic             w_done, w_tmo;
  logic [1:0]       w_clr, w_cap;

  // Next-state, grant, completion and pending-bit logic
  always_comb begin
    w_state  = r_state;
    w_last   = r_last;
    w_grant  = r_grant;
    w_wd     = r_wd;
    w_rd     = r_rd;
    w_ack    = '0;
    w_err    = '0;
    w_addr_s = r_addr_s;
    w_wd_s   = r_wd_s;
    w_we_s   = r_we_s;
    w_req_s  = 1'b0;
    w_done   = 1'b0;
    w_tmo    = 1'b0;
    w_clr    = '0;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_grant  = (&r_pend) ? ~r_last : r_pend[1];
          w_addr_s = r_buf_addr[w_grant];
          w_wd_s   = r_buf_wd[w_grant];
          w_we_s   = r_buf_we[w_grant];
          w_req_s  = 1'b1;
          w_state  = S_REQ;
        end
      end
      S_REQ: begin
        if (req_ack_s) begin
          w_done = 1'b1;
        end else begin
          w_state = S_WAIT;
          w_wd    = '0;
        end
      end
      S_WAIT: begin
        w_wd = r_wd + cnt_w'(1);
        if (req_ack_s) begin
          w_done = 1'b1;
        end else if (r_wd == cnt_w'(timeout_c - 2)) begin
          // the watchdog reaches timeout_c-1 on this edge
          w_done = 1'b1;
          w_tmo  = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
    if (w_done) begin
      w_rd[r_grant]  = w_tmo ? '0 : rd_s;
      w_ack[r_grant] = 1'b1;
      w_err[r_grant] = w_tmo;
      w_clr[r_grant] = 1'b1;
      w_last         = r_grant;
      w_we_s         = 1'b0;
      w_state        = S_IDLE;
    end
    // a new request on its own master's completion edge is kept (set wins)
    w_cap  = req_m & (~r_pend | w_clr);
    w_pend = (r_pend & ~w_clr) | w_cap;
  end

  // FSM, control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pend   <= '0;
      r_last   <= 1'b1;
      r_grant  <= 1'b0;
      r_wd     <= '0;
      r_rd     <= '0;
      r_ack    <= '0;
      r_err    <= '0;
      r_addr_s <= '0;
      r_wd_s   <= '0;
      r_we_s   <= 1'b0;
      r_req_s  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pend   <= w_pend;
      r_last   <= w_last;
      r_grant  <= w_grant;
      r_wd     <= w_wd;
      r_rd     <= w_rd;
      r_ack    <= w_ack;
      r_err    <= w_err;
      r_addr_s <= w_addr_s;
      r_wd_s   <= w_wd_s;
      r_we_s   <= w_we_s;
      r_req_s  <= w_req_s;
    end
  end

  // Per-master request buffers, loaded only on capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_addr <= '0;
      r_buf_wd   <= '0;
      r_buf_we   <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (w_cap[i]) begin
          r_buf_addr[i] <= addr_m[i];
          r_buf_wd[i]   <= wd_m[i];
          r_buf_we[i]   <= we_m[i];
        end
      end
    end
  end

  assign rd_m      = r_rd;
  assign req_ack_m = r_ack;
  assign err_m     = r_err;
  assign addr_s    = r_addr_s;
  assign wd_s      = r_wd_s;
  assign we_s      = r_we_s;
  assign req_s     = r_req_s;

endmodule
